// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-2 FFT datapath.
// Q1.14 complex samples, saturation helper.
package fft_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 14;

  localparam logic signed [DATA_WIDTH-1:0] Q_ONE  = 16'sd16384;
  localparam logic signed [DATA_WIDTH-1:0] Q_HALF = 16'sd8192;

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
  } cplx_t;

  function automatic logic signed [DATA_WIDTH-1:0] sat17to16(
    input logic signed [DATA_WIDTH:0] s
  );
    logic signed [DATA_WIDTH-1:0] r;
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
      r = s[DATA_WIDTH]
        ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
        : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      r = s[DATA_WIDTH-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_butterfly_r2_zmul.sv
// Combinational Q1.14 complex multiplier P = B*W.
// Products are floored by FRAC_BITS and truncated to DATA_WIDTH.
module z_multiplier
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH,
  parameter int FRAC_BITS  = fft_pkg::FRAC_BITS
) (
  input  logic [DATA_WIDTH-1:0] b_re_i,
  input  logic [DATA_WIDTH-1:0] b_im_i,
  input  logic [DATA_WIDTH-1:0] w_re_i,
  input  logic [DATA_WIDTH-1:0] w_im_i,
  output logic [DATA_WIDTH-1:0] p_re_o,
  output logic [DATA_WIDTH-1:0] p_im_o
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0] rr, ii, ri, ir;
  logic signed [PW:0]   re_full, im_full;

  assign rr = $signed(b_re_i) * $signed(w_re_i);
  assign ii = $signed(b_im_i) * $signed(w_im_i);
  assign ri = $signed(b_re_i) * $signed(w_im_i);
  assign ir = $signed(b_im_i) * $signed(w_re_i);

  assign re_full = {rr[PW-1], rr} - {ii[PW-1], ii};
  assign im_full = {ri[PW-1], ri} + {ir[PW-1], ir};

  // slicing at FRAC_BITS is an arithmetic shift plus truncation
  assign p_re_o = re_full[FRAC_BITS +: DATA_WIDTH];
  assign p_im_o = im_full[FRAC_BITS +: DATA_WIDTH];

endmodule

// File: rtl/fft_butterfly_r2.sv
// Pipelined radix-2 DIT butterfly: X = A + B*W, Y = A - B*W.
// Two-stage valid/ready pipeline with scaling/saturation and group counter.
module fft_butterfly_r2
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH,
  parameter int FRAC_BITS  = fft_pkg::FRAC_BITS,
  parameter int SCALE      = 1,
  parameter int N_POINTS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a_re,
  input  logic [DATA_WIDTH-1:0] a_im,
  input  logic [DATA_WIDTH-1:0] b_re,
  input  logic [DATA_WIDTH-1:0] b_im,
  input  logic [DATA_WIDTH-1:0] w_re,
  input  logic [DATA_WIDTH-1:0] w_im,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] x_re,
  output logic [DATA_WIDTH-1:0] x_im,
  output logic [DATA_WIDTH-1:0] y_re,
  output logic [DATA_WIDTH-1:0] y_im,
  output logic                  out_last,
  output logic                  ovf,
  input  logic                  clr_ovf
);

  localparam int HALF = N_POINTS / 2;
  localparam int CW   = $clog2(HALF);
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  cplx_t a_q, b_q, w_q;
  cplx_t x_q, y_q, x_d, y_d;
  cplx_t p;
  logic  s1_valid_q, out_valid_q, ovf_q;
  logic [CW-1:0] cnt_q;

  logic s2_adv, s1_adv, accept, s2_load, out_fire;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = s2_adv;
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;
  assign s2_load  = s2_adv && s1_valid_q;
  assign out_fire = out_valid_q && out_ready;

  z_multiplier #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_zmul (
    .b_re_i(b_q.re),
    .b_im_i(b_q.im),
    .w_re_i(w_q.re),
    .w_im_i(w_q.im),
    .p_re_o(p.re),
    .p_im_o(p.im)
  );

  // Result in low bits, saturation flag in the MSB.
  function automatic logic [DATA_WIDTH:0] fold(
    input logic signed [DATA_WIDTH:0] s
  );
    logic [DATA_WIDTH:0] r;
    if (SCALE != 0) begin
      r = {1'b0, s[DATA_WIDTH:1]};
    end else begin
      r = {s[DATA_WIDTH] != s[DATA_WIDTH-1], sat17to16(s)};
    end
    return r;
  endfunction

  logic signed [DATA_WIDTH:0] sx_re, sx_im, sy_re, sy_im;
  logic [DATA_WIDTH:0] fx_re, fx_im, fy_re, fy_im;
  logic sat_any;

  assign sx_re = {a_q.re[DATA_WIDTH-1], a_q.re} + {p.re[DATA_WIDTH-1], p.re};
  assign sx_im = {a_q.im[DATA_WIDTH-1], a_q.im} + {p.im[DATA_WIDTH-1], p.im};
  assign sy_re = {a_q.re[DATA_WIDTH-1], a_q.re} - {p.re[DATA_WIDTH-1], p.re};
  assign sy_im = {a_q.im[DATA_WIDTH-1], a_q.im} - {p.im[DATA_WIDTH-1], p.im};

  assign fx_re = fold(sx_re);
  assign fx_im = fold(sx_im);
  assign fy_re = fold(sy_re);
  assign fy_im = fold(sy_im);

  assign x_d.re = fx_re[DATA_WIDTH-1:0];
  assign x_d.im = fx_im[DATA_WIDTH-1:0];
  assign y_d.re = fy_re[DATA_WIDTH-1:0];
  assign y_d.im = fy_im[DATA_WIDTH-1:0];

  assign sat_any = fx_re[DATA_WIDTH] | fx_im[DATA_WIDTH]
                 | fy_re[DATA_WIDTH] | fy_im[DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      w_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (accept) begin
        a_q <= {a_re, a_im};
        b_q <= {b_re, b_im};
        w_q <= {w_re, w_im};
      end
      if (s2_adv) out_valid_q <= s1_valid_q;
      if (s2_load) begin
        x_q <= x_d;
        y_q <= y_d;
      end
      if (out_fire) cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      // a new saturation outranks a same-cycle clear
      if (s2_load && sat_any) ovf_q <= 1'b1;
      else if (clr_ovf)       ovf_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign x_re      = x_q.re;
  assign x_im      = x_q.im;
  assign y_re      = y_q.re;
  assign y_im      = y_q.im;
  assign out_last  = out_valid_q && (cnt_q == LAST);
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fft_butterfly_r2.sv
// Scoreboard bench: SCALE=1 and SCALE=0 instances driven in lockstep.
// Directed vectors carry hand-computed results for both modes.
module tb_fft_butterfly_r2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic clr_ovf = 1'b0;
  logic [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic [15:0] w_re = '0, w_im = '0;

  logic in_ready1, out_valid1, out_last1, ovf1;
  logic [15:0] x_re1, x_im1, y_re1, y_im1;
  logic in_ready0, out_valid0, out_last0, ovf0;
  logic [15:0] x_re0, x_im0, y_re0, y_im0;

  fft_butterfly_r2 #(.SCALE(1), .N_POINTS(8)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready1),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid1), .out_ready(out_ready),
    .x_re(x_re1), .x_im(x_im1), .y_re(y_re1), .y_im(y_im1),
    .out_last(out_last1), .ovf(ovf1), .clr_ovf(clr_ovf)
  );

  fft_butterfly_r2 #(.SCALE(0), .N_POINTS(8)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready0),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid0), .out_ready(out_ready),
    .x_re(x_re0), .x_im(x_im0), .y_re(y_re0), .y_im(y_im0),
    .out_last(out_last0), .ovf(ovf0), .clr_ovf(clr_ovf)
  );

  // a_re a_im b_re b_im w_re w_im | X,Y scaled | X,Y saturated
  int tv [8][14] = '{
    '{  8192,      0,  8192,     0, 16384,      0,
        8192,      0,     0,     0, 16384,      0,     0,      0},
    '{     0,      0,  8192,     0,     0, -16384,
           0,  -4096,     0,  4096,     0,  -8192,     0,   8192},
    '{ 24576,      0, 16384,     0, 16384,      0,
       20480,      0,  4096,     0, 32767,      0,  8192,      0},
    '{-24576,      0, 16384,     0, -16384,     0,
      -20480,      0, -4096,     0, -32768,     0, -8192,      0},
    '{     1,     -3,     0,     0,     0,      0,
           0,     -2,     0,    -2,     1,     -3,     1,     -3},
    '{  1000,   2000,  8192,  4096,  8192,  -8192,
        3572,    -24, -2572,  2024,  7144,    -48, -5144,   4048},
    '{     0,      0,     1,     0,    -1,      0,
          -1,      0,     0,     0,    -1,      0,     1,      0},
    '{     0, -20000,     0, 16384, 16384,      0,
           0,  -1808,     0, -18192,    0,  -3616,     0, -32768}
  };

  typedef struct packed {
    logic [63:0] e1;
    logic [63:0] e0;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;
  int pos = 0;
  int last_mask = 0;
  bit rnd_en = 1'b0;

  function automatic logic [15:0] lo16(input int v);
    return v[15:0];
  endfunction

  function automatic logic [63:0] pk(input int a, input int b,
                                     input int c, input int d);
    return {a[15:0], b[15:0], c[15:0], d[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic send(input int k);
    bit acc;
    acc = 1'b0;
    a_re = lo16(tv[k][0]);
    a_im = lo16(tv[k][1]);
    b_re = lo16(tv[k][2]);
    b_im = lo16(tv[k][3]);
    w_re = lo16(tv[k][4]);
    w_im = lo16(tv[k][5]);
    in_valid = 1'b1;
    for (int c = 0; c < 64 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (acc) begin
      sbq.push_back('{
        e1: pk(tv[k][6], tv[k][7], tv[k][8], tv[k][9]),
        e0: pk(tv[k][10], tv[k][11], tv[k][12], tv[k][13])});
    end else begin
      checks++;
      failures++;
      $display("FAIL accept_timeout vec=%0d got=no_accept want=accept", k);
    end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((sbq.size() != 0 || out_valid1) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=%0d pending want=0", sbq.size());
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pos = 0;
        last_mask = 0;
      end else begin
        if (out_valid1 || out_valid0)
          chk("lockstep_valid", 64'(out_valid0), 64'(out_valid1));
        if (out_valid1 && out_ready) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output got=%0h want=none",
                     {x_re1, x_im1, y_re1, y_im1});
          end else begin
            e = sbq.pop_front();
            chk("xy_scaled", {x_re1, x_im1, y_re1, y_im1}, e.e1);
            chk("xy_sat", {x_re0, x_im0, y_re0, y_im0}, e.e0);
            chk("out_last", 64'(out_last1), 64'((pos % 4) == 3));
          end
          if (out_last1 && pos < 16) last_mask |= (1 << pos);
          pos++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid1), 64'd0);
    chk("rst_in_ready", 64'(in_ready1), 64'd1);
    chk("rst_out_last", 64'(out_last1), 64'd0);
    chk("rst_ovf", 64'(ovf0), 64'd0);
    chk("rst_xy", {x_re1, x_im1, y_re1, y_im1}, 64'd0);

    @(posedge clk);
    #1;
    send(0);
    chk("latency_c1", 64'(out_valid1), 64'd0);
    @(posedge clk);
    #1;
    chk("latency_c2", 64'(out_valid1), 64'd1);
    send(1);
    send(2);
    wait_empty();
    chk("ovf_set", 64'(ovf0), 64'd1);
    chk("ovf_scaled_clear", 64'(ovf1), 64'd0);

    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    chk("ovf_clr", 64'(ovf0), 64'd0);

    send(7);
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    chk("ovf_set_wins", 64'(ovf0), 64'd1);
    wait_empty();

    out_ready = 1'b0;
    send(4);
    send(5);
    a_re = lo16(tv[6][0]);
    a_im = lo16(tv[6][1]);
    b_re = lo16(tv[6][2]);
    b_im = lo16(tv[6][3]);
    w_re = lo16(tv[6][4]);
    w_im = lo16(tv[6][5]);
    in_valid = 1'b1;
    begin
      int stalls;
      stalls = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (!in_ready1) stalls++;
      end
      chk("bp_stall", 64'(stalls), 64'd4);
    end
    chk("bp_accepted", 64'(sbq.size()), 64'd2);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(6);
    wait_empty();

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rnd_en = 1'b1;
    for (int i = 0; i < 8; i++) send(i);
    rnd_en = 1'b0;
    out_ready = 1'b1;
    wait_empty();
    chk("last_positions", 64'(last_mask), 64'h88);
    chk("ovf_scaled_never", 64'(ovf1), 64'd0);

    send(0);
    wait_empty();
    out_ready = 1'b0;
    send(2);
    send(4);
    chk("inflight_ovf", 64'(ovf0), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    chk("midrst_out_valid", 64'(out_valid1), 64'd0);
    chk("midrst_ovf", 64'(ovf0), 64'd0);
    chk("midrst_in_ready", 64'(in_ready1), 64'd1);
    chk("midrst_out_last", 64'(out_last1), 64'd0);
    out_ready = 1'b1;
    for (int i = 3; i < 7; i++) send(i);
    wait_empty();
    chk("midrst_last_pos", 64'(last_mask), 64'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
